// File: rtl/result_streamer.sv
// result_streamer
// Drains a block of result words out of a synchronous-read memory (mem3) and
// presents them on a valid/ready output stream. A 2-entry prefetch buffer
// hides the one-cycle read latency so that, with m_ready held high, one word
// is delivered per cycle after the first.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; prefetch buffer empty
// RUN    | issuing reads and streaming words until the last one is taken
// FINISH | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, num_results  drain request and word count (sampled in IDLE only)
//   rd_en, rd_addr      memory read strobe and address
//   rd_data             memory read data, valid one cycle after rd_en
//   m_valid, m_ready    output stream handshake
//   m_data, m_last      output word, final-word marker
//   busy, done          drain in progress, one-cycle completion pulse
//   sent_count          words accepted downstream in the current/last drain
module result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_results,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sent_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state;
    logic [ADDR_WIDTH:0]     n_words;
    logic [ADDR_WIDTH:0]     issued;
    logic                    rd_pending;
    logic                    head_valid;
    logic                    tail_valid;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [DATA_WIDTH-1:0]   tail_data;
    logic                    pop;
    logic                    push;
    logic [1:0]              reserved;

    assign pop  = head_valid & m_ready;
    assign push = rd_pending;

    // Buffer slots already claimed (held words plus the read whose data is on
    // rd_data now), minus the word leaving this cycle. Crediting the pop is
    // what allows back-to-back reads when the consumer never stalls.
    assign reserved = {1'b0, head_valid} + {1'b0, tail_valid}
                    + {1'b0, rd_pending} - {1'b0, pop};

    assign rd_en   = (state == RUN) && (issued < n_words) && (reserved < 2'd2);
    assign rd_addr = issued[ADDR_WIDTH-1:0];

    assign m_valid = head_valid;
    assign m_data  = head_data;
    // The head is always word number sent_count of this drain.
    assign m_last  = head_valid && (sent_count == (n_words - ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_words    <= '0;
            issued     <= '0;
            rd_pending <= 1'b0;
            head_valid <= 1'b0;
            tail_valid <= 1'b0;
            head_data  <= '0;
            tail_data  <= '0;
            sent_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_pending <= rd_en;
            if (rd_en) begin
                issued <= issued + ONE;
            end
            if (pop) begin
                sent_count <= sent_count + ONE;
            end

            if (push && pop) begin
                if (tail_valid) begin
                    head_data <= tail_data;
                    tail_data <= rd_data;
                end else begin
                    head_data <= rd_data;
                end
            end else if (pop) begin
                head_data  <= tail_data;
                head_valid <= tail_valid;
                tail_valid <= 1'b0;
            end else if (push) begin
                if (!head_valid) begin
                    head_data  <= rd_data;
                    head_valid <= 1'b1;
                end else begin
                    tail_data  <= rd_data;
                    tail_valid <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        n_words    <= (num_results > MAX_N) ? MAX_N : num_results;
                        sent_count <= '0;
                        issued     <= '0;
                    end
                end
                RUN: begin
                    // An empty request still spends one RUN cycle so its done
                    // pulse lands two cycles after start.
                    if ((n_words == '0) || (pop && m_last)) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer
// Directed bench for result_streamer: a table of drains (count, ready
// pattern, expected words and done cycle) plus a hand-written mid-drain
// reset sequence. The memory model returns 0x10 + address.
module tb_result_streamer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] num_results;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;
    logic [4:0] sent_count;

    int checks;
    int failures;

    result_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_results(num_results),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem3 model: one-cycle read latency; garbage when not read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= 8'h10 + {4'h0, rd_addr};
        else       rd_data <= 8'hEE;
    end

    typedef struct {
        int n;
        int mode;       // 0: ready always, 1: 1,0,0,1,0,1 pattern, 2: random
        int exp_words;
        int exp_done;   // cycle after start edge of done pulse, 0 = not checked
        int restart;    // cycle at which a stray start is driven, 0 = none
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        logic [5:0] pat;
        pat = 6'b101001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[(k - 1) % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"},      rd_en,      0);
        chk({tag, "_rd_addr"},    rd_addr,    0);
        chk({tag, "_m_valid"},    m_valid,    0);
        chk({tag, "_m_last"},     m_last,     0);
        chk({tag, "_m_data"},     m_data,     0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_done"},       done,       0);
        chk({tag, "_sent_count"}, sent_count, 0);
    endtask

    task automatic run_drain(input int n, input int mode, input int exp_words,
                             input int exp_done, input int restart);
        int         issued;
        int         accepted;
        int         done_cnt;
        int         done_at;
        int         first_valid;
        int         first_rd;
        logic       prev_stall;
        logic [7:0] prev_data;
        issued = 0; accepted = 0; done_cnt = 0; done_at = 0;
        first_valid = 0; first_rd = 0; prev_stall = 1'b0; prev_data = 8'h00;

        @(negedge clk);
        start       = 1'b1;
        num_results = 5'(n);
        @(posedge clk);
        #1;
        start       = 1'b0;
        num_results = 5'd9;

        for (int k = 1; k <= 200 && (done_at == 0 || k <= done_at + 2); k++) begin
            m_ready = ready_for(mode, k);
            start   = (k == restart);
            if (start) num_results = 5'd3;
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data",  m_data,  prev_data);
            end
            if (rd_en) begin
                chk("rd_addr", rd_addr, issued);
                if (first_rd == 0) first_rd = k;
                issued++;
            end
            if (m_valid && first_valid == 0) first_valid = k;
            if (m_valid && m_ready) begin
                chk("data", m_data, 8'h10 + accepted);
                chk("last", m_last, (accepted == exp_words - 1));
                accepted++;
            end
            chk("outstanding", (issued - accepted) <= 2, 1);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
                chk("busy_in_done", busy, 0);
                chk("sent_count_done", sent_count, exp_words);
            end else if (done_at == 0) begin
                chk("busy_run", busy, 1);
            end else begin
                chk("idle_after_done", {busy, rd_en, m_valid}, 0);
                chk("sent_count_hold", sent_count, exp_words);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        m_ready = 1'b0;

        chk("done_seen", done_at != 0, 1);
        chk("done_count", done_cnt, 1);
        chk("words_accepted", accepted, exp_words);
        chk("reads_issued", issued, exp_words);
        if (exp_done != 0) chk("done_cycle", done_at, exp_done);
        if (exp_words > 0) begin
            chk("first_rd_cycle",    first_rd,    1);
            chk("first_valid_cycle", first_valid, 3);
        end else begin
            chk("no_rd",    first_rd,    0);
            chk("no_valid", first_valid, 0);
        end
    endtask

    initial begin
        int accepted;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        num_results = 5'd0;
        m_ready = 1'b0;

        vecs[0] = '{n: 4,  mode: 0, exp_words: 4,  exp_done: 7,  restart: 0};
        vecs[1] = '{n: 4,  mode: 1, exp_words: 4,  exp_done: 0,  restart: 0};
        vecs[2] = '{n: 0,  mode: 0, exp_words: 0,  exp_done: 2,  restart: 0};
        vecs[3] = '{n: 20, mode: 0, exp_words: 16, exp_done: 19, restart: 0};
        vecs[4] = '{n: 1,  mode: 0, exp_words: 1,  exp_done: 4,  restart: 0};
        vecs[5] = '{n: 16, mode: 2, exp_words: 16, exp_done: 0,  restart: 0};
        vecs[6] = '{n: 5,  mode: 0, exp_words: 5,  exp_done: 8,  restart: 3};
        vecs[7] = '{n: 3,  mode: 1, exp_words: 3,  exp_done: 0,  restart: 2};
        vecs[8] = '{n: 2,  mode: 0, exp_words: 2,  exp_done: 5,  restart: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_drain(vecs[i].n, vecs[i].mode, vecs[i].exp_words,
                      vecs[i].exp_done, vecs[i].restart);
        end

        // Reset in the middle of a drain with a stalled head word.
        @(negedge clk);
        start       = 1'b1;
        num_results = 5'd4;
        @(posedge clk);
        #1;
        start    = 1'b0;
        accepted = 0;
        for (int k = 1; k <= 5; k++) begin
            m_ready = (k <= 4);
            if (k == 5) rst_n = 1'b0;
            @(negedge clk);
            if (m_valid && m_ready) accepted++;
            @(posedge clk);
            #1;
        end
        chk("abort_accepted", accepted, 2);
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_done", {done, busy, m_valid, rd_en}, 0);
        end
        m_ready = 1'b0;
        run_drain(4, 0, 4, 7, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
